// File: rtl/fft_sink_framer_pkg.sv
// Shared definitions for the FFT sink framer: FSM state encoding, default
// widths, the Avalon-ST "no error" code and the FFT-length clamp helper.
package fft_pkg;

  localparam int FFT_DATA_W   = 14;
  localparam int FFT_MAX_LOG2 = 10;
  localparam int FFT_MIN_LOG2 = 3;

  localparam logic [1:0] AVST_ERR_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2
  } state_t;

  // Limit a requested log2(N) to the range the core supports.
  function automatic logic [3:0] clamp_log2(input logic [3:0] req,
                                            input int unsigned lo,
                                            input int unsigned hi);
    int unsigned r;
    r = {28'd0, req};
    if (r < lo) return lo[3:0];
    if (r > hi) return hi[3:0];
    return req;
  endfunction

endpackage

// File: rtl/fft_sink_framer_if.sv
// Avalon-ST sink bus towards the FFT core, plus the per-frame side-band
// (direction and length) that the core samples alongside the packet.
//
// Handshake: a beat moves when sink_valid && sink_ready are both high on a
// rising clock edge. Once sink_valid is high, the master keeps sink_valid,
// sink_sop, sink_eop, sink_real and sink_imag unchanged until that beat moves;
// sink_ready may change at any time and never depends on sink_valid.
interface fft_sink_framer_if #(
  parameter int DATA_W   = 14,
  parameter int MAX_LOG2 = 10
);
  logic                sink_valid;
  logic                sink_ready;
  logic                sink_sop;
  logic                sink_eop;
  logic [DATA_W-1:0]   sink_real;
  logic [DATA_W-1:0]   sink_imag;
  logic [1:0]          sink_error;
  logic                inverse;
  logic [MAX_LOG2:0]   fft_pts;

  // Framer side.
  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
           inverse, fft_pts,
    input  sink_ready
  );

  // FFT core side.
  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
           inverse, fft_pts,
    output sink_ready
  );
endinterface

// File: rtl/fft_sink_framer_outreg.sv
// Single registered output stage (fft_sink_outreg). It accepts a new beat
// whenever it is empty or its current beat is being taken, and otherwise
// holds every output stable.
module fft_sink_outreg
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic              i_ready,
  output logic              o_can_load,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic              r_sop;
  logic              r_eop;
  logic [DATA_W-1:0] r_data;
  logic              w_can_load;

  assign w_can_load = !r_valid || i_ready;

  // Load a new beat (or go empty) only when the current beat is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
    end else if (w_can_load) begin
      r_valid <= i_load;
      r_sop   <= i_load & i_sop;
      r_eop   <= i_load & i_eop;
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_can_load = w_can_load;
  assign o_valid    = r_valid;
  assign o_sop      = r_sop;
  assign o_eop      = r_eop;
  assign o_data     = r_data;

endmodule

// File: rtl/fft_sink_framer.sv
// FFT sink framer: frames a real sample stream into N-point packets
// (N = 1 << clamped cfg_log2, latched at frame start) on the FFT core's
// Avalon-ST sink. An abort mid-frame switches to zero padding so the core
// always receives exactly N beats.
//
// Optional build macro FFT_SINK_FRAMER_STATS_EN adds frame_cnt (eop beats
// accepted by the core) and abort_cnt (STREAM -> PAD transitions).
module fft_sink_framer
  import fft_pkg::*;
#(
  parameter int DATA_W   = FFT_DATA_W,
  parameter int MAX_LOG2 = FFT_MAX_LOG2,
  parameter int MIN_LOG2 = FFT_MIN_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [3:0]          cfg_log2,
  input  logic                cfg_inverse,
  input  logic                abort,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  fft_sink_framer_if.master   sink,
  output logic                busy,
  output state_t              dbg_state
`ifdef FFT_SINK_FRAMER_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         abort_cnt
`endif
);

  state_t              r_state;
  logic [MAX_LOG2-1:0] r_index;
  logic                r_inverse;
  logic [MAX_LOG2:0]   r_fft_pts;

  logic                w_can_load;
  logic                w_in_ready;
  logic                w_xfer;
  logic                w_pad_load;
  logic                w_load;
  logic                w_last;
  logic                w_go_pad;
  logic [3:0]          w_log2;
  logic [MAX_LOG2:0]   w_pts_m1;
  logic [DATA_W-1:0]   w_load_data;
  logic                w_out_valid;
  logic                w_out_sop;
  logic                w_out_eop;
  logic [DATA_W-1:0]   w_out_data;

  // Handshake and beat-position decode for the current cycle.
  assign w_pts_m1    = r_fft_pts - (MAX_LOG2+1)'(1);
  assign w_last      = (r_index == w_pts_m1[MAX_LOG2-1:0]);
  assign w_in_ready  = (r_state == STREAM) && w_can_load;
  assign w_xfer      = in_valid && w_in_ready;
  assign w_pad_load  = (r_state == PAD) && w_can_load;
  assign w_load      = w_xfer || w_pad_load;
  assign w_load_data = (r_state == STREAM) ? in_data : '0;
  assign w_go_pad    = (r_state == STREAM) && abort && !(w_xfer && w_last);
  assign w_log2      = clamp_log2(cfg_log2, MIN_LOG2, MAX_LOG2);

  // Frame FSM: latches per-frame config, walks the beat index, handles abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_inverse <= 1'b0;
      r_fft_pts <= (MAX_LOG2+1)'(1) << MAX_LOG2;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state   <= STREAM;
            r_index   <= '0;
            r_inverse <= cfg_inverse;
            r_fft_pts <= (MAX_LOG2+1)'(1) << w_log2;
          end
        end
        STREAM: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state <= IDLE;
              r_index <= '0;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
          // An abort that coincides with the eop transfer is simply ignored.
          if (w_go_pad) begin
            r_state <= PAD;
          end
        end
        PAD: begin
          if (w_pad_load) begin
            if (w_last) begin
              r_state <= IDLE;
              r_index <= '0;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_index <= '0;
        end
      endcase
    end
  end

  fft_sink_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_sop      (r_index == '0),
    .i_eop      (w_last),
    .i_ready    (sink.sink_ready),
    .o_can_load (w_can_load),
    .o_valid    (w_out_valid),
    .o_sop      (w_out_sop),
    .o_eop      (w_out_eop),
    .o_data     (w_out_data)
  );

`ifdef FFT_SINK_FRAMER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_abort_cnt;

  // Count completed packets taken by the core and frames cut short by abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_out_valid && sink.sink_ready && w_out_eop) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_go_pad) begin
        r_abort_cnt <= r_abort_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign abort_cnt = r_abort_cnt;
`endif

  assign in_ready        = w_in_ready;
  assign busy            = (r_state != IDLE);
  assign dbg_state       = r_state;
  assign sink.sink_valid = w_out_valid;
  assign sink.sink_sop   = w_out_sop;
  assign sink.sink_eop   = w_out_eop;
  assign sink.sink_real  = w_out_data;
  assign sink.sink_imag  = '0;
  assign sink.sink_error = AVST_ERR_NONE;
  assign sink.inverse    = r_inverse;
  assign sink.fft_pts    = r_fft_pts;

endmodule
